// File: rtl/mel_energy_serializer.sv
// Serializes one captured vector of mel filterbank energies into a valid/ready beat stream.
// Optional MEL_LOG2_EN: each beat carries a piecewise-linear log2 (Q5.FRAC_BITS) of the energy.
module mel_energy_serializer #(
    parameter int NUM_FILTERS = 40,
    parameter int FRAC_BITS   = 8
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [31:0]                    filtered_data_in [NUM_FILTERS-1:0],
    input  logic                           filtered_valid_in,
    output logic                           filtered_ready_out,
    output logic [31:0]                    mel_data_out,
    output logic                           mel_valid_out,
    output logic                           mel_last_out,
    output logic [$clog2(NUM_FILTERS)-1:0] mel_index_out,
    input  logic                           mel_ready_in
);

    localparam int IDX_W = $clog2(NUM_FILTERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FILTERS - 1);

    if (NUM_FILTERS < 2) begin : g_bad_num_filters
        $error("mel_energy_serializer: NUM_FILTERS must be >= 2");
    end
    if (FRAC_BITS < 1 || FRAC_BITS > 26) begin : g_bad_frac_bits
        $error("mel_energy_serializer: FRAC_BITS must be in 1..26");
    end

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       buf_q [NUM_FILTERS-1:0];
    logic              capture;

`ifdef MEL_LOG2_EN
    // Normalise so the leading one sits at bit 31; the bits below it are the mantissa.
    function automatic logic [31:0] log2_q(input logic [31:0] v);
        logic [4:0]  msb;
        logic [31:0] norm;
        logic [31:0] res;
        msb = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) msb = 5'(i);
        end
        norm = v << (5'd31 - msb);
        res = '0;
        res[FRAC_BITS +: 5]    = msb;
        res[FRAC_BITS-1:0]     = norm[30 -: FRAC_BITS];
        if (v == '0) res = '0;
        return res;
    endfunction
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idx_q <= '0;
            for (int i = 0; i < NUM_FILTERS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            idx_q <= idx_d;
            if (capture) begin
                for (int i = 0; i < NUM_FILTERS; i++) begin
                    buf_q[i] <= filtered_data_in[i];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (filtered_valid_in) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (mel_ready_in) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs depend only on registered state, index and buffer.
    always_comb begin
        filtered_ready_out = (state_q == ST_IDLE);
        mel_valid_out      = (state_q == ST_STREAM);
        mel_last_out       = (state_q == ST_STREAM) && (idx_q == LAST_IDX);
        mel_index_out      = idx_q;
`ifdef MEL_LOG2_EN
        mel_data_out       = log2_q(buf_q[idx_q]);
`else
        mel_data_out       = buf_q[idx_q];
`endif
    end

endmodule

// File: tb/tb_mel_energy_serializer.sv
// Scoreboard bench for mel_energy_serializer: a 40-filter instance and a 3-filter instance.
module tb_mel_energy_serializer;

    localparam int NF  = 40;
    localparam int FB  = 8;
    localparam int IW  = $clog2(NF);
    localparam int NF3 = 3;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  idx;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] fdata [NF-1:0];
    logic        fvalid, fready;
    logic [31:0] mdata;
    logic        mvalid, mlast, mready;
    logic [IW-1:0] midx;

    logic [31:0] fdata3 [NF3-1:0];
    logic        fvalid3, fready3;
    logic [31:0] mdata3;
    logic        mvalid3, mlast3, mready3;
    logic [1:0]  midx3;

    mel_energy_serializer #(.NUM_FILTERS(NF), .FRAC_BITS(FB)) dut (
        .clk_in(clk), .rst_in(rst),
        .filtered_data_in(fdata), .filtered_valid_in(fvalid), .filtered_ready_out(fready),
        .mel_data_out(mdata), .mel_valid_out(mvalid), .mel_last_out(mlast),
        .mel_index_out(midx), .mel_ready_in(mready)
    );

    mel_energy_serializer #(.NUM_FILTERS(NF3), .FRAC_BITS(FB)) dut3 (
        .clk_in(clk), .rst_in(rst),
        .filtered_data_in(fdata3), .filtered_valid_in(fvalid3), .filtered_ready_out(fready3),
        .mel_data_out(mdata3), .mel_valid_out(mvalid3), .mel_last_out(mlast3),
        .mel_index_out(midx3), .mel_ready_in(mready3)
    );

    beat_t exp_q[$];
    beat_t exp3_q[$];
    int checks = 0, errors = 0;
    int valid_cycles = 0;
    int rmode = 0;
    bit prev_last = 0;
    logic [31:0] vec_a [NF-1:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: floor(log2) and the fractional bits below the leading one, via plain arithmetic.
    function automatic logic [31:0] model(input logic [31:0] v);
`ifdef MEL_LOG2_EN
        longint unsigned x, mant;
        int m;
        if (v == 0) return 32'd0;
        x = 64'(v);
        m = 0;
        while ((x >> (m + 1)) != 0) m++;
        mant = ((x << FB) >> m) % (64'd1 << FB);
        return 32'(longint'(m) * (64'd1 << FB) + mant);
`else
        return v;
`endif
    endfunction

    // Monitor for the 40-filter instance: every valid cycle is compared with the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_last) begin
                check("ready_after_last", 32'(fready), 32'd1);
                check("valid_after_last", 32'(mvalid), 32'd0);
            end
            prev_last = 0;
            if (mvalid) begin
                valid_cycles++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got index %0d data %h, expected no beat", midx, mdata);
                end else begin
                    check("beat_data",  mdata,       exp_q[0].data);
                    check("beat_index", 32'(midx),   32'(exp_q[0].idx));
                    check("beat_last",  32'(mlast),  32'(exp_q[0].last));
                    check("ready_low_in_stream", 32'(fready), 32'd0);
                    if (mready) begin
                        prev_last = exp_q[0].last;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end else begin
            prev_last = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst && mvalid3) begin
            if (exp3_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_beat3: got index %0d, expected no beat", midx3);
            end else begin
                check("beat3_data",  mdata3,      exp3_q[0].data);
                check("beat3_index", 32'(midx3),  32'(exp3_q[0].idx));
                check("beat3_last",  32'(mlast3), 32'(exp3_q[0].last));
                if (mready3) void'(exp3_q.pop_front());
            end
        end
    end

    initial begin
        mready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0:       mready = 1'b1;
                1:       mready = mvalid ? !mready : 1'b1;
                default: mready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Waits for the capture edge of whatever is on fdata (= vec_a) and records its beats.
    task automatic capture_wait();
        int guard = 0;
        while (1) begin
            @(negedge clk);
            if (fready) break;
            guard++;
            if (guard > 2000) begin
                checks++; errors++;
                $display("FAIL capture_timeout: got ready low for %0d cycles, expected accept", guard);
                return;
            end
        end
        check("capture_after_drain", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < NF; i++) begin
            exp_q.push_back('{data: model(vec_a[i]), idx: 8'(i), last: (i == NF - 1)});
        end
    endtask

    task automatic send();
        @(posedge clk); #1;
        for (int i = 0; i < NF; i++) fdata[i] = vec_a[i];
        fvalid = 1'b1;
        capture_wait();
        @(posedge clk); #1;
        fvalid = 1'b0;
        for (int i = 0; i < NF; i++) fdata[i] = $urandom;
        @(negedge clk);
        check("beat0_latency", 32'(mvalid), 32'd1);
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_remaining", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0;
        rst = 1'b1; fvalid = 1'b0; fvalid3 = 1'b0; mready3 = 1'b1;
        for (int i = 0; i < NF; i++) fdata[i] = $urandom;
        for (int i = 0; i < NF3; i++) fdata3[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(fready), 32'd1);
        check("rst_valid", 32'(mvalid), 32'd0);
        check("rst_last",  32'(mlast),  32'd0);
        check("rst_index", 32'(midx),   32'd0);
        check("rst_data",  mdata,       32'd0);

        // Incrementing vector, downstream always ready.
        rmode = 0;
        for (int i = 0; i < NF; i++) vec_a[i] = 32'h100 + i;
        v0 = valid_cycles;
        send();
        wait_drain();
        check("valid_cycles_ready", 32'(valid_cycles - v0), 32'(NF));

        // Same vector, ready toggling every cycle.
        rmode = 1;
        v0 = valid_cycles;
        send();
        wait_drain();
        check("valid_cycles_toggle", 32'(valid_cycles - v0), 32'(2 * NF));

        // Second vector held valid throughout streaming of the first.
        rmode = 2;
        @(posedge clk); #1;
        for (int i = 0; i < NF; i++) vec_a[i] = $urandom;
        for (int i = 0; i < NF; i++) fdata[i] = vec_a[i];
        fvalid = 1'b1;
        capture_wait();
        @(posedge clk); #1;
        for (int i = 0; i < NF; i++) vec_a[i] = 32'hA000_0000 + i;
        for (int i = 0; i < NF; i++) fdata[i] = vec_a[i];
        capture_wait();
        @(posedge clk); #1;
        fvalid = 1'b0;
        wait_drain();

        // Reset in the middle of a vector.
        rmode = 0;
        for (int i = 0; i < NF; i++) vec_a[i] = $urandom;
        send();
        begin
            int guard = 0;
            while (!(mvalid && midx == IW'(17)) && guard < 200) begin
                @(posedge clk); #1;
                guard++;
            end
            check("reached_index17", 32'(midx), 32'd17);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(mvalid), 32'd0);
        check("midrst_index", 32'(midx),   32'd0);
        check("midrst_ready", 32'(fready), 32'd1);
        check("midrst_data",  mdata,       32'd0);
        for (int i = 0; i < NF; i++) vec_a[i] = 32'h5000 + i;
        send();
        wait_drain();

        // Log2-relevant corner values plus random vectors under random backpressure.
        rmode = 2;
        for (int i = 0; i < NF; i++) vec_a[i] = $urandom >> $urandom_range(0, 31);
        vec_a[0] = 32'd768; vec_a[1] = 32'd1; vec_a[2] = 32'd0; vec_a[3] = 32'hFFFF_FFFF;
        send();
        wait_drain();
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < NF; i++) vec_a[i] = $urandom >> $urandom_range(0, 31);
            send();
            wait_drain();
        end

        // Three-filter instance: two vectors, index 0,1,2,0,1,2.
        for (int n = 0; n < 2; n++) begin
            int guard;
            @(posedge clk); #1;
            for (int i = 0; i < NF3; i++) fdata3[i] = $urandom;
            fvalid3 = 1'b1;
            guard = 0;
            while (1) begin
                @(negedge clk);
                if (fready3 || guard > 50) break;
                guard++;
            end
            check("capture3_ready", 32'(fready3), 32'd1);
            for (int i = 0; i < NF3; i++)
                exp3_q.push_back('{data: model(fdata3[i]), idx: 8'(i), last: (i == NF3 - 1)});
            @(posedge clk); #1;
            fvalid3 = 1'b0;
            for (int i = 0; i < NF3; i++) fdata3[i] = $urandom;
        end
        begin
            int guard = 0;
            while (exp3_q.size() != 0 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            check("drain3_remaining", 32'(exp3_q.size()), 32'd0);
        end
        @(negedge clk);
        check("idle3_index", 32'(midx3),   32'd0);
        check("idle3_valid", 32'(mvalid3), 32'd0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
